// File: rtl/dct_out_merge_if.sv
// Bus bundle for dct_out_merge: steering inputs, both datapath row buses and the merged output.
// Valid-only protocol: a row moves on any cycle its valid is high; there is no ready, so the sink must always take it.
interface dct_out_merge_if #(
    parameter int COEF_W = 16,
    parameter int ROW_N  = 32
);
    logic                      i_start;
    logic                      i_inverse;
    logic [1:0]                i_size;
    logic                      i_valid0;
    logic [COEF_W*ROW_N-1:0]   i_data0;
    logic                      i_valid1;
    logic [COEF_W*ROW_N-1:0]   i_data1;
    logic                      o_valid;
    logic [COEF_W*ROW_N-1:0]   o_data;
    logic [4:0]                o_row;
    logic                      o_last;
    logic                      o_done;
    logic                      o_busy;
    logic                      o_err;
    logic                      o_dbg_state;

    modport master (
        output i_start, i_inverse, i_size, i_valid0, i_data0, i_valid1, i_data1,
        input  o_valid, o_data, o_row, o_last, o_done, o_busy, o_err, o_dbg_state
    );

    modport slave (
        input  i_start, i_inverse, i_size, i_valid0, i_data0, i_valid1, i_data1,
        output o_valid, o_data, o_row, o_last, o_done, o_busy, o_err, o_dbg_state
    );
endinterface

// File: rtl/dct_out_merge.sv
// Rejoins the forward and inverse transform paths into one registered row stream,
// counting rows per TU, marking the last row, pulsing done and flagging path errors.
module dct_out_merge #(
    parameter int COEF_W = 16,
    parameter int ROW_N  = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dct_out_merge_if.slave bus
);
    localparam int W = COEF_W * ROW_N;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           inv_q, inv_d;
    logic [1:0]     size_q, size_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   data_q, data_d;
    logic [4:0]     row_q, row_d;
    logic           last_q, last_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           err_q, err_d;

    logic           eff_run;
    logic           eff_inv;
    logic [1:0]     eff_size;
    logic [4:0]     eff_cnt;
    logic [4:0]     last_idx;
    logic           is_last;
    logic           both_v;
    logic           exp_v;
    logic           wrong_v;
    logic           err_now;
    logic           accept;

    // A start in the same cycle as a valid takes effect before the valid is judged.
    always_comb begin
        eff_run  = bus.i_start || (state_q == RUN);
        eff_inv  = bus.i_start ? bus.i_inverse : inv_q;
        eff_size = bus.i_start ? bus.i_size    : size_q;
        eff_cnt  = bus.i_start ? 5'd0          : cnt_q;

        last_idx = 5'd3;
        case (eff_size)
            2'd0:    last_idx = 5'd3;
            2'd1:    last_idx = 5'd7;
            2'd2:    last_idx = 5'd15;
            default: last_idx = 5'd31;
        endcase
        is_last = (eff_cnt == last_idx);

        both_v  = bus.i_valid0 && bus.i_valid1;
        exp_v   = eff_inv ? bus.i_valid1 : bus.i_valid0;
        wrong_v = eff_inv ? bus.i_valid0 : bus.i_valid1;
        accept  = eff_run && exp_v && !both_v;
        err_now = both_v
               || (!eff_run && (bus.i_valid0 || bus.i_valid1))
               || (eff_run && wrong_v);

        state_d = state_q;
        inv_d   = inv_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        if (bus.i_start) begin
            state_d = RUN;
            inv_d   = bus.i_inverse;
            size_d  = bus.i_size;
            cnt_d   = 5'd0;
        end
        if (accept) begin
            if (is_last) begin
                state_d = IDLE;
                cnt_d   = 5'd0;
            end else begin
                cnt_d   = eff_cnt + 5'd1;
            end
        end

        valid_d = accept;
        data_d  = accept ? (eff_inv ? bus.i_data1 : bus.i_data0) : data_q;
        row_d   = accept ? eff_cnt : row_q;
        last_d  = accept && is_last;
        done_d  = last_q;
        busy_d  = (state_d == RUN);
        err_d   = bus.i_start ? err_now : (err_q || err_now);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            inv_q   <= 1'b0;
            size_q  <= 2'd0;
            cnt_q   <= 5'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= 5'd0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_row       = row_q;
    assign bus.o_last      = last_q;
    assign bus.o_done      = done_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;
    assign bus.o_dbg_state = state_q;
endmodule

// File: tb/tb_dct_out_merge.sv
// Bench for dct_out_merge: directed TU scenarios plus random traffic, every cycle
// checked against a TU-level model of rows, last/done, busy and sticky error.
module tb_dct_out_merge;
    localparam int COEF_W = 16;
    localparam int ROW_N  = 32;
    localparam int W      = COEF_W * ROW_N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    dct_out_merge_if #(.COEF_W(COEF_W), .ROW_N(ROW_N)) bus ();

    dct_out_merge #(.COEF_W(COEF_W), .ROW_N(ROW_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_done       = 0;

    logic [W-1:0] exp_q[$];

    // Model state: whether a TU is open, its direction, its row count and next row index.
    bit           m_run;
    bit           m_inv;
    int           m_rows;
    int           m_cnt;
    logic         e_valid, e_last, e_done, e_busy, e_err;
    logic [4:0]   e_row;
    logic [W-1:0] e_data;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_row();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_run = 0; m_inv = 0; m_rows = 4; m_cnt = 0;
        e_valid = 0; e_last = 0; e_done = 0; e_busy = 0; e_err = 0;
        e_row = '0; e_data = '0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit st, v0, v1, live, ok, bad;
        st = bus.i_start; v0 = bus.i_valid0; v1 = bus.i_valid1;
        e_done = e_last;
        if (st) begin
            m_inv  = bus.i_inverse;
            m_rows = 4 << bus.i_size;
            m_cnt  = 0;
            m_run  = 1;
        end
        live = m_run;
        ok   = live && !(v0 && v1) && (m_inv ? v1 : v0);
        bad  = (v0 && v1) || (!live && (v0 || v1)) || (live && (m_inv ? v0 : v1));
        if (ok) begin
            e_valid = 1;
            e_row   = 5'(m_cnt);
            e_last  = (m_cnt == m_rows - 1);
            e_data  = m_inv ? bus.i_data1 : bus.i_data0;
            exp_q.push_back(e_data);
            m_cnt++;
            if (m_cnt == m_rows) begin
                m_cnt = 0;
                m_run = 0;
            end
        end else begin
            e_valid = 0;
            e_last  = 0;
        end
        e_err  = st ? bad : (e_err || bad);
        e_busy = m_run;
    endtask

    task automatic compare_all();
        check("valid", W'(bus.o_valid), W'(e_valid));
        check("row",   W'(bus.o_row),   W'(e_row));
        check("last",  W'(bus.o_last),  W'(e_last));
        check("done",  W'(bus.o_done),  W'(e_done));
        check("busy",  W'(bus.o_busy),  W'(e_busy));
        check("err",   W'(bus.o_err),   W'(e_err));
        check("state", W'(bus.o_dbg_state), W'(e_busy));
        if (e_valid && exp_q.size() > 0) check("data", bus.o_data, exp_q.pop_front());
        else check("data_hold", bus.o_data, e_data);
        if (bus.o_done) n_done++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit st, input bit inv, input logic [1:0] sz, input bit v0, input bit v1);
        bus.i_start   = st;
        bus.i_inverse = inv;
        bus.i_size    = sz;
        bus.i_valid0  = v0;
        bus.i_valid1  = v1;
        bus.i_data0   = rand_row();
        bus.i_data1   = rand_row();
        tick();
    endtask

    task automatic set_idle();
        bus.i_start = 0; bus.i_inverse = 0; bus.i_size = '0;
        bus.i_valid0 = 0; bus.i_valid1 = 0;
        bus.i_data0 = '0; bus.i_data1 = '0;
    endtask

    initial begin
        int  done_before;
        bit  st, inv, pth;
        logic [1:0] sz;
        int  r;

        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;

        // Forward 4x4, back-to-back rows
        done_before = n_done;
        drive(1, 0, 2'd0, 0, 0);
        repeat (4) drive(0, 0, 2'd0, 1, 0);
        repeat (3) drive(0, 0, 2'd0, 0, 0);
        check("fwd4_done_count", W'(n_done - done_before), W'(1));

        // Inverse 32x32 with idle gaps
        done_before = n_done;
        drive(1, 1, 2'd3, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(0, 0, 2'd0, 0, 1);
            repeat ($urandom_range(0, 2)) drive(0, 0, 2'd0, 0, 0);
        end
        repeat (3) drive(0, 0, 2'd0, 0, 0);
        check("inv32_done_count", W'(n_done - done_before), W'(1));

        // Wrong path at row 2 of an inverse 8x8, then start clears err
        drive(1, 1, 2'd1, 0, 0);
        repeat (2) drive(0, 0, 2'd0, 0, 1);
        drive(0, 0, 2'd0, 1, 0);
        repeat (6) drive(0, 0, 2'd0, 0, 1);
        repeat (2) drive(0, 0, 2'd0, 0, 0);
        check("err_sticky", W'(bus.o_err), W'(1));

        // Start with data, forward 8x8; also clears the error
        drive(1, 0, 2'd1, 1, 0);
        repeat (7) drive(0, 0, 2'd0, 1, 0);
        repeat (3) drive(0, 0, 2'd0, 0, 0);

        // Abort a 16x16 after row 5 with an inverse 4x4
        done_before = n_done;
        drive(1, 0, 2'd2, 0, 0);
        repeat (6) drive(0, 0, 2'd0, 1, 0);
        drive(1, 1, 2'd0, 0, 0);
        repeat (4) drive(0, 0, 2'd0, 0, 1);
        repeat (3) drive(0, 0, 2'd0, 0, 0);
        check("abort_done_count", W'(n_done - done_before), W'(1));

        // Reset in the middle of a 32x32
        drive(1, 1, 2'd3, 0, 0);
        repeat (11) drive(0, 0, 2'd0, 0, 1);
        set_idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 2'd0, 0, 1);
        check("err_after_reset", W'(bus.o_err), W'(1));
        drive(0, 0, 2'd0, 0, 0);

        // Random traffic: starts, aborts, wrong path, double valids
        for (int i = 0; i < 600; i++) begin
            st  = ($urandom_range(0, 19) == 0);
            inv = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            pth = st ? inv : m_inv;
            r   = $urandom_range(0, 9);
            if (r < 6)       drive(st, inv, sz, !pth, pth);
            else if (r == 6) drive(st, inv, sz, pth, !pth);
            else if (r == 7) drive(st, inv, sz, 1, 1);
            else             drive(st, inv, sz, 0, 0);
        end
        repeat (3) drive(0, 0, 2'd0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule

// File: doc/dct_out_merge.md
# dct_out_merge

Output-side collector for the 2D transform datapath. The valid steering in front of the datapath sends each TU down the forward path (mux1 side) or the inverse path (mux3 side). This block rejoins the two paths into one registered row stream for the downstream quant / reconstruction stage. It counts rows per TU, flags the last row, pulses completion, and flags any valid that arrives on the wrong path.

## Interface
Parameters:
- COEF_W, 16, bits per coefficient
- ROW_N, 32, coefficients per row bus (max TU width)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse: a new TU begins; latches i_inverse and i_size
- i_inverse  in  1  0 = forward TU (expect path 0), 1 = inverse TU (expect path 1)
- i_size  in  2  TU size: 0 = 4x4, 1 = 8x8, 2 = 16x16, 3 = 32x32
- i_valid0  in  1  row valid from the forward path
- i_data0  in  COEF_W*ROW_N  row data from the forward path
- i_valid1  in  1  row valid from the inverse path
- i_data1  in  COEF_W*ROW_N  row data from the inverse path
- o_valid  out  1  merged row valid
- o_data  out  COEF_W*ROW_N  merged row data
- o_row  out  5  row index of o_data within the TU
- o_last  out  1  high with o_valid on the final row of the TU
- o_done  out  1  one-cycle pulse the cycle after o_last
- o_busy  out  1  TU in progress (RUN state)
- o_err  out  1  sticky protocol error, cleared by i_start

## Operation
- Latched mode: inv_q and size_q are captured on i_start. Rows per TU: rows_q = 4 << size_q, so 4, 8, 16 or 32.
- FSM states:
  - IDLE: o_busy = 0.
  - RUN: o_busy = 1.
- Transitions:
  - IDLE -> RUN on i_start.
  - RUN -> IDLE when the last row is accepted, i.e. cnt == rows_q-1 together with a valid on the expected path.
  - RUN -> RUN on i_start: abort and restart. Re-latch the mode, reset cnt to 0, no o_done for the aborted TU.
- Accepted row: a valid on the expected path while in RUN (path 1 if inv_q, else path 0).
  - The registered outputs get o_valid = 1, o_data = that path's data, o_row = cnt, and o_last = (cnt == rows_q-1).
  - cnt then increments, or returns to 0 after the last row.
- i_start and a valid in the same cycle: i_start wins the mode decision. The valid is judged against the newly presented i_inverse/i_size and, if legal, is accepted as row 0 (cnt becomes 1).
- Errors: o_err is set and the row is dropped (o_valid stays 0) for any of:
  - a valid on the unexpected path in RUN;
  - any valid in IDLE without i_start;
  - i_valid0 and i_valid1 both high in the same cycle. Neither row is accepted, and cnt is unchanged.
- o_err clears on i_start unless that same cycle raises a new error.
- o_data holds its last value when o_valid = 0.
- o_row is 5 bits and never exceeds 31. cnt wraps only via the last-row rule.

## Timing
- Latency is 1 cycle from an input valid to o_valid. All outputs are registered.
- There is no backpressure. One row can be accepted per cycle, back-to-back.
- o_done is high the cycle after o_last = 1. o_busy is already 0 in that cycle.
- A new TU may start in the same cycle o_done is high.
- Reset (async assert, deassertion synchronised to clk) forces:
  - state IDLE, cnt 0;
  - o_valid, o_data, o_row, o_last, o_done, o_busy and o_err all 0.
- Reset mid-TU drops the TU silently: no o_done and no o_err.

## Test plan
- Forward 4x4: i_start with i_inverse=0, i_size=0, then i_valid0 for 4 consecutive cycles with data D0..D3. Required: o_valid on the next 4 cycles, o_row 0..3, o_data D0..D3, o_last on row 3, o_done 1 cycle later, and o_busy low from the o_done cycle.
- Inverse 32x32 with gaps: i_inverse=1, i_size=3, and 32 i_valid1 pulses with idle cycles between them. Required: o_row 0..31 in order, o_last only on row 31, exactly one o_done, o_err=0.
- Wrong path: inverse 8x8 TU, then an i_valid0 pulse at row 2. Required: no o_valid for that cycle, o_err=1 and sticky, and the next i_valid1 emitted as o_row=2. The next i_start clears o_err.
- Start with data: i_start with i_inverse=0, i_size=1 and i_valid0 in the same cycle. Required: o_valid with o_row=0 next cycle. After 7 more rows, o_last on row 7.
- Abort: 16x16 TU, and i_start (i_inverse=1, i_size=0) after row 5. Required: no o_done for the 16x16 TU. The following 4 i_valid1 rows come out as o_row 0..3, followed by o_done.
- Reset mid-TU: assert rst_n=0 asynchronously after row 10 of a 32x32 TU. Required: all outputs 0 immediately. After release, i_valid1 without i_start sets o_err=1.
